// File: rtl/io_map_pkg.sv
// Memory-mapped IO layout and TX handshake state, shared by the store demux and the IO read path.
package io_map_pkg;

  localparam logic [31:0] IO_BASE    = 32'hFFFF_FC00;

  localparam logic [7:0]  IO_LED_OFS = 8'h00;
  localparam logic [7:0]  IO_SEG_OFS = 8'h04;
  localparam logic [7:0]  IO_TX_OFS  = 8'h08;

  typedef enum logic {
    TX_IDLE    = 1'b0,
    TX_PENDING = 1'b1
  } tx_state_t;

  // Word-granular offset match: byte lane bits Addr[1:0] never take part in IO decode.
  function automatic logic ofs_match(input logic [7:0] ofs_a, input logic [7:0] ofs_b);
    return ofs_a[7:2] == ofs_b[7:2];
  endfunction

endpackage

// File: rtl/io_addr_decoder.sv
// Combinational decode of a store address into the IO window and its individual register hits.
module io_addr_decoder #(
  parameter int                 DATA_W  = 32,
  parameter logic [DATA_W-1:0]  IO_BASE = io_map_pkg::IO_BASE
) (
  input  logic [DATA_W-1:0] Addr,
  output logic              io,
  output logic              led_hit,
  output logic              seg_hit,
  output logic              tx_hit,
  output logic              unmapped
);
  import io_map_pkg::*;

  logic [7:0] ofs;

  assign ofs = Addr[7:0];

  always_comb begin
    io       = (Addr[DATA_W-1:8] == IO_BASE[DATA_W-1:8]);
    led_hit  = io & ofs_match(ofs, IO_LED_OFS);
    seg_hit  = io & ofs_match(ofs, IO_SEG_OFS);
    tx_hit   = io & ofs_match(ofs, IO_TX_OFS);
    unmapped = io & ~(led_hit | seg_hit | tx_hit);
  end

endmodule

// File: rtl/store_demux.sv
// Steers each CPU store to data memory or to the LED / 7-seg / UART TX peripherals.
// Memory, LED and SEG paths are registered; TX is a valid/ready slot that stalls the core when busy.
module store_demux #(
  parameter int                 DATA_W  = 32,
  parameter logic [DATA_W-1:0]  IO_BASE = io_map_pkg::IO_BASE,
  parameter int                 LED_W   = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              WriteEn,
  input  logic [DATA_W-1:0] Addr,
  input  logic [DATA_W-1:0] WriteData,
  output logic              Stall,
  output logic              MemWriteEn,
  output logic [DATA_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWriteData,
  output logic [LED_W-1:0]  LedOut,
  output logic [DATA_W-1:0] SegOut,
  output logic              TxValid,
  output logic [7:0]        TxData,
  input  logic              TxReady,
  output logic              AddrErr
);
  import io_map_pkg::*;

  logic io_p0;
  logic led_hit_p0;
  logic seg_hit_p0;
  logic tx_hit_p0;
  logic unmapped_p0;

  io_addr_decoder #(
    .DATA_W  (DATA_W),
    .IO_BASE (IO_BASE)
  ) u_dec (
    .Addr     (Addr),
    .io       (io_p0),
    .led_hit  (led_hit_p0),
    .seg_hit  (seg_hit_p0),
    .tx_hit   (tx_hit_p0),
    .unmapped (unmapped_p0)
  );

  logic mem_wr_p0;
  logic led_wr_p0;
  logic seg_wr_p0;
  logic tx_wr_p0;
  logic err_wr_p0;
  logic tx_stall_p0;
  logic tx_accept_p0;

  tx_state_t                tx_state_p1;
  logic                     mem_we_p1;
  logic [DATA_W-1:0]        mem_addr_p1;
  logic [DATA_W-1:0]        mem_data_p1;
  logic [LED_W-1:0]         led_p1;
  logic [DATA_W-1:0]        seg_p1;
  logic [7:0]               tx_data_p1;
  logic                     addr_err_p1;

  // Stage p0: request qualification against the decoded target.
  always_comb begin
    mem_wr_p0    = WriteEn & ~io_p0;
    led_wr_p0    = WriteEn & led_hit_p0;
    seg_wr_p0    = WriteEn & seg_hit_p0;
    tx_wr_p0     = WriteEn & tx_hit_p0;
    err_wr_p0    = WriteEn & unmapped_p0;
    // The only back-pressure source: TX slot still occupied and the transmitter not draining it.
    tx_stall_p0  = tx_wr_p0 & (tx_state_p1 == TX_PENDING) & ~TxReady;
    tx_accept_p0 = tx_wr_p0 & ~tx_stall_p0;
  end

  assign Stall = tx_stall_p0;

  // Stage p1: registered memory, peripheral and TX state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      tx_state_p1 <= TX_IDLE;
      mem_we_p1   <= 1'b0;
      mem_addr_p1 <= '0;
      mem_data_p1 <= '0;
      led_p1      <= '0;
      seg_p1      <= '0;
      tx_data_p1  <= '0;
      addr_err_p1 <= 1'b0;
    end else begin
      mem_we_p1   <= mem_wr_p0;
      mem_addr_p1 <= Addr;
      mem_data_p1 <= WriteData;
      addr_err_p1 <= err_wr_p0;

      if (led_wr_p0) begin
        led_p1 <= WriteData[LED_W-1:0];
      end
      if (seg_wr_p0) begin
        seg_p1 <= WriteData;
      end

      if (tx_accept_p0) begin
        tx_data_p1 <= WriteData[7:0];
      end

      case (tx_state_p1)
        TX_IDLE: begin
          if (tx_accept_p0) begin
            tx_state_p1 <= TX_PENDING;
          end
        end
        TX_PENDING: begin
          // A handshake with a fresh accepted write refills the slot without a bubble.
          if (TxReady && !tx_accept_p0) begin
            tx_state_p1 <= TX_IDLE;
          end
        end
        default: tx_state_p1 <= TX_IDLE;
      endcase
    end
  end

  assign MemWriteEn   = mem_we_p1;
  assign MemAddr      = mem_addr_p1;
  assign MemWriteData = mem_data_p1;
  assign LedOut       = led_p1;
  assign SegOut       = seg_p1;
  assign TxValid      = (tx_state_p1 == TX_PENDING);
  assign TxData       = tx_data_p1;
  assign AddrErr      = addr_err_p1;

endmodule
